// File: rtl/display_7_seg_mux_if.sv
// display_7_seg_mux_if: value/attribute inputs and pin outputs of the 7-segment scanner
//   master: drives number_in, dp_in, blank_in, lz_suppress, brightness; receives SEG, DIGIT, frame_start
//   slave : the scanner side of the same signals
interface display_7_seg_mux_if #(
   parameter int N_DIGITS = 8
);
   logic [4*N_DIGITS-1:0] number_in;
   logic [N_DIGITS-1:0]   dp_in;
   logic [N_DIGITS-1:0]   blank_in;
   logic                  lz_suppress;
   logic [3:0]            brightness;
   logic [7:0]            SEG;
   logic [N_DIGITS-1:0]   DIGIT;
   logic                  frame_start;
   modport master (
      output number_in, dp_in, blank_in, lz_suppress, brightness,
      input  SEG, DIGIT, frame_start
   );
   modport slave (
      input  number_in, dp_in, blank_in, lz_suppress, brightness,
      output SEG, DIGIT, frame_start
   );
endinterface

// File: rtl/display_7_seg_mux.sv
// display_7_seg_mux: time-multiplexed driver for N common-anode 7-segment digits
//   CLK   : system clock, posedge
//   RST_N : asynchronous active-low reset
//   io    : slave side of display_7_seg_mux_if (hex value, dp, blanking, lz suppress,
//           brightness in; active-low SEG/DIGIT and frame_start pulse out, all registered)
module display_7_seg_mux #(
   parameter int N_DIGITS = 8,
   parameter int PRESCALE = 50000
) (
   input logic                CLK,
   input logic                RST_N,
   display_7_seg_mux_if.slave io
);
   localparam int CW = $clog2(PRESCALE);
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   // (brightness+1)*PRESCALE needs up to 5 extra bits before the >>4
   localparam int TW = CW + 5;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*N_DIGITS-1:0] num_q, num_e;
   logic [N_DIGITS-1:0]   dp_q, dp_e, blank_q, blank_e, sup, digit_q, digit_d;
   logic                  lz_q, lz_e, started_q, tick, frame, z, on;
   logic [TW-1:0]         thr;
   logic [3:0]            nib;
   logic [7:0]            seg_q, seg_d;
   logic                  fs_q;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   always_comb begin
      tick  = cnt_q == CW'(PRESCALE - 1);
      frame = tick && (idx_q == IW'(N_DIGITS - 1));
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      idx_d = !tick ? idx_q : frame ? '0 : idx_q + IW'(1);
      // On the frame edge digit 0 is decoded from the live inputs being latched,
      // so it appears without a frame of latency.
      num_e   = frame ? io.number_in   : num_q;
      dp_e    = frame ? io.dp_in       : dp_q;
      blank_e = frame ? io.blank_in    : blank_q;
      lz_e    = frame ? io.lz_suppress : lz_q;
      // Walk from the MS digit down; z stays set while everything above is a dark zero.
      z   = 1'b1;
      sup = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         z      = z & (num_e[4*i +: 4] == 4'h0) & ~dp_e[i];
         sup[i] = lz_e & z & (i != 0);
      end
      nib = num_e[{idx_d, 2'b00} +: 4];
      thr = TW'(((TW'(io.brightness) + TW'(1)) * TW'(PRESCALE)) >> 4);
      // Nothing is lit before the first frame snapshot exists.
      on      = (started_q | frame) & (TW'(cnt_d) < thr) & ~blank_e[idx_d] & ~sup[idx_d];
      digit_d = on ? ~(N_DIGITS'(1) << idx_d) : '1;
      seg_d   = on ? {~dp_e[idx_d], hex7(nib)} : 8'hFF;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q     <= '0;
         idx_q     <= IW'(N_DIGITS - 1);
         num_q     <= '0;
         dp_q      <= '0;
         blank_q   <= '0;
         lz_q      <= 1'b0;
         started_q <= 1'b0;
         seg_q     <= 8'hFF;
         digit_q   <= '1;
         fs_q      <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         num_q     <= num_e;
         dp_q      <= dp_e;
         blank_q   <= blank_e;
         lz_q      <= lz_e;
         started_q <= started_q | frame;
         seg_q     <= seg_d;
         digit_q   <= digit_d;
         fs_q      <= frame;
      end
   end

   assign io.SEG         = seg_q;
   assign io.DIGIT       = digit_q;
   assign io.frame_start = fs_q;
endmodule

// File: tb/tb_display_7_seg_mux.sv
// tb_display_7_seg_mux: directed checks of the 7-segment scanner (8-digit and 5-digit builds)
module tb_display_7_seg_mux;
   logic clk = 1'b0;
   logic rst_n, rst_b_n;
   int   cyc, cyc_b;
   int   n_chk, n_pass;
   logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   logic [4:0] seq_b [5] = '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h0F};

   display_7_seg_mux_if #(.N_DIGITS(8)) bus_a ();
   display_7_seg_mux_if #(.N_DIGITS(5)) bus_b ();

   display_7_seg_mux #(.N_DIGITS(8), .PRESCALE(16)) dut_a (.CLK(clk), .RST_N(rst_n), .io(bus_a));
   display_7_seg_mux #(.N_DIGITS(5), .PRESCALE(16)) dut_b (.CLK(clk), .RST_N(rst_b_n), .io(bus_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc   <= rst_n   ? cyc + 1   : 0;
   always @(posedge clk) cyc_b <= rst_b_n ? cyc_b + 1 : 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
   endtask

   task automatic at(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic at_b(input int c);
      while (cyc_b < c) @(negedge clk);
   endtask

   task automatic startup();
      for (int k = 1; k <= 15; k++) begin
         at(k);
         chk("pre_tick_digit", bus_a.DIGIT, 8'hFF);
      end
      chk("pre_tick_seg", bus_a.SEG, 8'hFF);
      at(16);
      chk("tick_digit", bus_a.DIGIT, 8'hFE);
      chk("tick_seg", bus_a.SEG, 8'h92);
      chk("tick_fs", bus_a.frame_start, 1);
      at(17);
      chk("fs_one_cycle", bus_a.frame_start, 0);
      chk("slot0_seg_hold", bus_a.SEG, 8'h92);
      at(32);
      chk("slot1_digit", bus_a.DIGIT, 8'hFD);
      chk("slot1_seg", bus_a.SEG, 8'h88);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int on;
      logic [7:0] e;
      logic [4:0] d;
      n_chk = 0;
      n_pass = 0;
      rst_n = 1'b0;
      rst_b_n = 1'b0;
      bus_a.number_in = 32'h0000_00A5;
      bus_a.dp_in = 8'h00;
      bus_a.blank_in = 8'h00;
      bus_a.lz_suppress = 1'b1;
      bus_a.brightness = 4'd15;
      bus_b.number_in = 20'h0;
      bus_b.dp_in = 5'h0;
      bus_b.blank_in = 5'h0;
      bus_b.lz_suppress = 1'b0;
      bus_b.brightness = 4'd15;
      repeat (3) @(negedge clk);
      chk("rst_seg", bus_a.SEG, 8'hFF);
      chk("rst_digit", bus_a.DIGIT, 8'hFF);
      chk("rst_fs", bus_a.frame_start, 0);
      chk("rst_b_digit", bus_b.DIGIT, 5'h1F);
      rst_n = 1'b1;
      startup();
      for (int s = 2; s <= 7; s++) begin
         at(16 + 16 * s);
         chk("lz_digit", bus_a.DIGIT, 8'hFF);
         chk("lz_seg", bus_a.SEG, 8'hFF);
      end
      at(143);
      chk("fs_before_frame2", bus_a.frame_start, 0);
      at(144);
      chk("fs_frame2", bus_a.frame_start, 1);
      chk("frame2_digit", bus_a.DIGIT, 8'hFE);
      bus_a.dp_in = 8'h10;
      at(208);
      chk("dp_midframe_ignored", bus_a.DIGIT, 8'hFF);
      at(272);
      chk("fs_frame3", bus_a.frame_start, 1);
      at(304);
      chk("dp_slot2_seg", bus_a.SEG, 8'hC0);
      chk("dp_slot2_digit", bus_a.DIGIT, 8'hFB);
      at(320);
      chk("dp_slot3_seg", bus_a.SEG, 8'hC0);
      chk("dp_slot3_digit", bus_a.DIGIT, 8'hF7);
      at(336);
      chk("dp_slot4_seg", bus_a.SEG, 8'h40);
      chk("dp_slot4_digit", bus_a.DIGIT, 8'hEF);
      at(352);
      chk("dp_slot5_digit", bus_a.DIGIT, 8'hFF);
      at(360);
      bus_a.number_in = 32'h0;
      bus_a.dp_in = 8'h00;
      bus_a.lz_suppress = 1'b0;
      bus_a.brightness = 4'd3;
      on = 0;
      for (int k = 400; k < 416; k++) begin
         at(k);
         if (k == 400) begin
            chk("pwm3_first_digit", bus_a.DIGIT, 8'hFE);
            chk("pwm3_first_seg", bus_a.SEG, 8'hC0);
         end
         if (bus_a.DIGIT == 8'hFE) on++;
      end
      chk("pwm3_slot0_on", on, 4);
      on = 0;
      for (int k = 448; k < 464; k++) begin
         at(k);
         if (bus_a.DIGIT == 8'hF7) on++;
      end
      chk("pwm3_slot3_on", on, 4);
      at(470);
      bus_a.brightness = 4'd0;
      on = 0;
      for (int k = 480; k < 496; k++) begin
         at(k);
         if (bus_a.DIGIT == 8'hDF) on++;
      end
      chk("pwm0_slot5_on", on, 1);
      at(500);
      bus_a.brightness = 4'd15;
      at(580);
      bus_a.number_in = 32'h7654_3210;
      at(592);
      chk("mid_slot4_seg", bus_a.SEG, 8'hC0);
      chk("mid_slot4_digit", bus_a.DIGIT, 8'hEF);
      at(640);
      chk("mid_slot7_seg", bus_a.SEG, 8'hC0);
      chk("mid_slot7_digit", bus_a.DIGIT, 8'h7F);
      for (int s = 0; s < 8; s++) begin
         at(656 + 16 * s);
         e = ~(8'h01 << s);
         chk("dec_lo_seg", bus_a.SEG, tbl[s]);
         chk("dec_lo_digit", bus_a.DIGIT, e);
         if (s == 2) begin
            at(700);
            bus_a.number_in = 32'hFEDC_BA98;
            bus_a.blank_in = 8'h80;
         end
      end
      for (int s = 0; s < 8; s++) begin
         at(784 + 16 * s);
         e = (s == 7) ? 8'hFF : ~(8'h01 << s);
         chk("dec_hi_seg", bus_a.SEG, (s == 7) ? 8'hFF : tbl[8 + s]);
         chk("dec_hi_digit", bus_a.DIGIT, e);
      end
      at(917);
      chk("pre_async_digit", bus_a.DIGIT, 8'hFE);
      chk("pre_async_seg", bus_a.SEG, 8'h80);
      #2 rst_n = 1'b0;
      #1;
      chk("async_seg", bus_a.SEG, 8'hFF);
      chk("async_digit", bus_a.DIGIT, 8'hFF);
      chk("async_fs", bus_a.frame_start, 0);
      bus_a.number_in = 32'h0000_00A5;
      bus_a.dp_in = 8'h00;
      bus_a.blank_in = 8'h00;
      bus_a.lz_suppress = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      startup();
      @(negedge clk);
      rst_b_n = 1'b1;
      for (int k = 1; k <= 170; k++) begin
         at_b(k);
         d = bus_b.DIGIT;
         chk("b_digit_valid", (d == 5'h1F) || ($countones(~d) == 1), 1);
         chk("b_fs", bus_b.frame_start, (k % 80) == 16);
         if (k < 16) chk("b_pre_tick", d, 5'h1F);
         if (k >= 16 && (k % 16) == 0) begin
            chk("b_seq", d, seq_b[(k / 16 - 1) % 5]);
            chk("b_seg", bus_b.SEG, 8'hC0);
         end
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
